digit_frame_sequencer: RTL and testbench

Frame-synchronous controller that configures the VGA digit-sprite overlay. Samples scoreboard and game-clock values once per frame at the vertical blanking boundary, converts remaining seconds to M:SS digits with an iterative subtract engine, clamps all digits to the sprite range, and commits every digit simultaneously, so a frame never shows a mix of old and new digits. Sits between the game logic/processor registers and the VGA controller's `score1/score2/time1/time2/time3` inputs.

---
 rtl/digit_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_digit_frame_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_sequencer.sv
// rtl/digit_frame_sequencer.sv - frame-synchronous M:SS / score digit sequencer for the VGA sprite overlay
//
// Samples the scores and remaining seconds once per frame on the rising edge
// of screenEnd. Seconds are converted to M:SS by repeated subtraction. All
// digits are clamped to the sprite range and committed on one clock edge, so
// a frame never shows a mix of old and new digits.
//
// Optional feature macro: DIGIT_BLINK_EN (time-digit blink when time is low).
//
// Ports:
//   clk          in   100 MHz system clock
//   reset_n      in   asynchronous active-low reset
//   screenEnd    in   frame-boundary level from the timing generator
//   freeze       in   hold the current display, skip captures
//   score1_in    in   player 1 score, binary
//   score2_in    in   player 2 score, binary
//   time_sec_in  in   remaining seconds, binary
//   score1/2     out  clamped score sprite indices
//   time1/2/3    out  minutes / tens of seconds / ones of seconds
//   busy         out  conversion in progress
//   frame_tick   out  one-cycle pulse on the edge that commits the digits
//   overrun      out  sticky: a frame edge arrived while busy
//   time_blank   out  blank the time digits (blink build only, else 0)

module digit_frame_sequencer #(
    parameter int unsigned MAX_DIGIT    = 9,
    parameter int unsigned SEC_PER_MIN  = 60,
    parameter int unsigned BLINK_THRESH = 10,
    parameter int unsigned BLINK_HALF   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        screenEnd,
    input  logic        freeze,
    input  logic [31:0] score1_in,
    input  logic [31:0] score2_in,
    input  logic [31:0] time_sec_in,
    output logic [31:0] score1,
    output logic [31:0] score2,
    output logic [31:0] time1,
    output logic [31:0] time2,
    output logic [31:0] time3,
    output logic        busy,
    output logic        frame_tick,
    output logic        overrun,
    output logic        time_blank
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_MIN     = 3'd2;
    localparam logic [2:0] S_TEN     = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;

    localparam logic [31:0] C_MAX       = 32'(MAX_DIGIT);
    localparam logic [31:0] C_SPM       = 32'(SEC_PER_MIN);
    localparam logic [31:0] C_SAT_LIMIT = 32'((MAX_DIGIT + 1) * SEC_PER_MIN);
    localparam logic [31:0] C_SAT_VALUE = 32'(MAX_DIGIT * SEC_PER_MIN + 59);

    logic [2:0]  r_state;
    logic        r_se_d;
    logic        r_armed;
    logic [31:0] r_shadow1;
    logic [31:0] r_shadow2;
    logic [31:0] r_rem;
    logic [31:0] r_m;
    logic [31:0] r_t;
    logic [31:0] r_score1;
    logic [31:0] r_score2;
    logic [31:0] r_time1;
    logic [31:0] r_time2;
    logic [31:0] r_time3;
    logic        r_frame_tick;
    logic        r_overrun;
    logic        w_start;

    // r_armed is low only in the first cycle after reset. If screenEnd is
    // already high at release, r_se_d picks it up in that cycle and the
    // stale level never looks like a rising edge.
    assign w_start = screenEnd & ~r_se_d & r_armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_se_d       <= 1'b0;
            r_armed      <= 1'b0;
            r_shadow1    <= '0;
            r_shadow2    <= '0;
            r_rem        <= '0;
            r_m          <= '0;
            r_t          <= '0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_time1      <= '0;
            r_time2      <= '0;
            r_time3      <= '0;
            r_frame_tick <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_se_d       <= screenEnd;
            r_armed      <= 1'b1;
            r_frame_tick <= 1'b0;

            // A frame edge while a conversion is running is dropped and flagged.
            if (w_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start && !freeze) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_shadow1 <= score1_in;
                    r_shadow2 <= score2_in;
                    r_rem     <= (time_sec_in >= C_SAT_LIMIT) ? C_SAT_VALUE : time_sec_in;
                    r_m       <= '0;
                    r_t       <= '0;
                    r_state   <= S_MIN;
                end
                S_MIN: begin
                    if (r_rem >= C_SPM) begin
                        r_rem <= r_rem - C_SPM;
                        r_m   <= r_m + 32'd1;
                    end else begin
                        r_state <= S_TEN;
                    end
                end
                S_TEN: begin
                    if (r_rem >= 32'd10) begin
                        r_rem <= r_rem - 32'd10;
                        r_t   <= r_t + 32'd1;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_time1      <= r_m;
                    r_time2      <= r_t;
                    r_time3      <= r_rem;
                    r_score1     <= (r_shadow1 > C_MAX) ? C_MAX : r_shadow1;
                    r_score2     <= (r_shadow2 > C_MAX) ? C_MAX : r_shadow2;
                    r_frame_tick <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign score1     = r_score1;
    assign score2     = r_score2;
    assign time1      = r_time1;
    assign time2      = r_time2;
    assign time3      = r_time3;
    assign busy       = (r_state != S_IDLE);
    assign frame_tick = r_frame_tick;
    assign overrun    = r_overrun;

`ifdef DIGIT_BLINK_EN
    localparam int BLINK_BIT = $clog2(BLINK_HALF);

    logic [15:0] r_frame_cnt;
    logic        r_time_blank;
    logic [31:0] w_secs;

    // Seconds actually being committed (after the 9:59 clamp).
    assign w_secs = (r_m * C_SPM) + (r_t * 32'd10) + r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt  <= '0;
            r_time_blank <= 1'b0;
        end else begin
            if (r_frame_tick) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_state == S_COMMIT) begin
                r_time_blank <= (w_secs <= 32'(BLINK_THRESH)) & r_frame_cnt[BLINK_BIT];
            end
        end
    end

    assign time_blank = r_time_blank;
`else
    logic w_unused_blink_params;
    assign w_unused_blink_params = ^{32'(BLINK_THRESH), 32'(BLINK_HALF)};
    assign time_blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_frame_sequencer.sv
// tb/tb_digit_frame_sequencer.sv - scoreboard bench for digit_frame_sequencer
`timescale 1ns/1ps

module tb_digit_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        screenEnd = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] score1_in = '0;
    logic [31:0] score2_in = '0;
    logic [31:0] time_sec_in = '0;
    logic [31:0] score1, score2, time1, time2, time3;
    logic        busy, frame_tick, overrun, time_blank;

    digit_frame_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .screenEnd   (screenEnd),
        .freeze      (freeze),
        .score1_in   (score1_in),
        .score2_in   (score2_in),
        .time_sec_in (time_sec_in),
        .score1      (score1),
        .score2      (score2),
        .time1       (time1),
        .time2       (time2),
        .time3       (time3),
        .busy        (busy),
        .frame_tick  (frame_tick),
        .overrun     (overrun),
        .time_blank  (time_blank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s1, s2, t1, t2, t3;
        int          ft_cyc;
        logic        blank;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every frame_tick must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && frame_tick) begin
            if (sb_q.size() == 0) begin
                check("unexpected_tick", {31'd0, frame_tick}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("score1", score1, mon_e.s1);
                check("score2", score2, mon_e.s2);
                check("time1", time1, mon_e.t1);
                check("time2", time2, mon_e.t2);
                check("time3", time3, mon_e.t3);
                check("tick_cycle", 32'(cyc), 32'(mon_e.ft_cyc));
                check("time_blank", {31'd0, time_blank}, {31'd0, mon_e.blank});
            end
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(negedge clk);
    endtask

    // One frame: present inputs with a screenEnd rising edge, disturb the
    // inputs after the capture cycle, then wait for the commit.
    task automatic run_frame(input logic [31:0] tsec, input logic [31:0] s1i, input logic [31:0] s2i,
                             input logic [31:0] et1, input logic [31:0] et2, input logic [31:0] et3,
                             input logic [31:0] es1, input logic [31:0] es2,
                             input int lat, input logic eblank);
        exp_t e;
        @(negedge clk);
        time_sec_in = tsec;
        score1_in   = s1i;
        score2_in   = s2i;
        screenEnd   = 1'b1;
        e.s1 = es1; e.s2 = es2; e.t1 = et1; e.t2 = et2; e.t3 = et3;
        e.ft_cyc = cyc + 1 + lat;
        e.blank  = eblank;
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        time_sec_in = 32'd3;
        score1_in   = 32'd1;
        score2_in   = 32'd1;
        @(negedge clk);
        screenEnd = 1'b0;
        wait_drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_score1", score1, 32'd0);
        check("rst_time1", time1, 32'd0);
        check("rst_time3", time3, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // tsec, s1, s2 -> t1, t2, t3, s1, s2, latency (4+m+t)
        run_frame(32'd125,  32'd3,  32'd7,  32'd2, 32'd0, 32'd5, 32'd3, 32'd7, 6,  1'b0);
        run_frame(32'd1000, 32'd42, 32'd7,  32'd9, 32'd5, 32'd9, 32'd9, 32'd7, 18, 1'b0);
        run_frame(32'd0,    32'd0,  32'd0,  32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4,  1'b0);
        run_frame(32'd59,   32'd9,  32'd10, 32'd0, 32'd5, 32'd9, 32'd9, 32'd9, 9,  1'b0);
        run_frame(32'd60,   32'd8,  32'd0,  32'd1, 32'd0, 32'd0, 32'd8, 32'd0, 5,  1'b0);
        run_frame(32'd600,  32'hFFFF_FFFF, 32'd1, 32'd9, 32'd5, 32'd9, 32'd9, 32'd1, 18, 1'b0);
        run_frame(32'd599,  32'd10, 32'd2,  32'd9, 32'd5, 32'd9, 32'd9, 32'd2, 18, 1'b0);
        run_frame(32'd10,   32'd4,  32'd5,  32'd0, 32'd1, 32'd0, 32'd4, 32'd5, 5,  1'b0);
        check("overrun_clear", {31'd0, overrun}, 32'd0);

        // Overrun: second edge 5 cycles after the first, while busy
        begin
            exp_t e;
            @(negedge clk);
            time_sec_in = 32'd599; score1_in = 32'd1; score2_in = 32'd2;
            screenEnd = 1'b1;
            e.s1 = 32'd1; e.s2 = 32'd2; e.t1 = 32'd9; e.t2 = 32'd5; e.t3 = 32'd9;
            e.ft_cyc = cyc + 1 + 18;
            e.blank = 1'b0;
            sb_q.push_back(e);
            repeat (2) @(negedge clk);
            screenEnd = 1'b0;
            repeat (3) @(negedge clk);
            check("ovr_busy", {31'd0, busy}, 32'd1);
            screenEnd = 1'b1;
            repeat (2) @(negedge clk);
            screenEnd = 1'b0;
            wait_drain();
            repeat (20) @(negedge clk);
            check("overrun_set", {31'd0, overrun}, 32'd1);
        end

        // Freeze: edges are ignored, display holds
        @(negedge clk);
        freeze = 1'b1;
        time_sec_in = 32'd100; score1_in = 32'd5; score2_in = 32'd6;
        for (int i = 0; i < 3; i++) begin
            screenEnd = 1'b1;
            repeat (3) begin @(negedge clk); check("freeze_busy", {31'd0, busy}, 32'd0); end
            screenEnd = 1'b0;
            repeat (3) begin @(negedge clk); check("freeze_busy", {31'd0, busy}, 32'd0); end
        end
        check("freeze_s1", score1, 32'd1);
        check("freeze_s2", score2, 32'd2);
        check("freeze_t1", time1, 32'd9);
        check("freeze_t2", time2, 32'd5);
        check("freeze_t3", time3, 32'd9);
        freeze = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during MIN, with screenEnd held high across release
        @(negedge clk);
        time_sec_in = 32'd599; score1_in = 32'd3; score2_in = 32'd4;
        screenEnd = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        check("arst_score1", score1, 32'd0);
        check("arst_score2", score2, 32'd0);
        check("arst_time1", time1, 32'd0);
        check("arst_time2", time2, 32'd0);
        check("arst_time3", time3, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        check("arst_blank", {31'd0, time_blank}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin @(negedge clk); check("armed_busy", {31'd0, busy}, 32'd0); end
        screenEnd = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(32'd599, 32'd3, 32'd4, 32'd9, 32'd5, 32'd9, 32'd3, 32'd4, 18, 1'b0);

`ifdef DIGIT_BLINK_EN
        do_reset();
        for (int k = 0; k < 64; k++) begin
            run_frame(32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd0, 32'd0, 4, ((k / 16) % 2) == 1);
        end
        for (int k = 0; k < 32; k++) begin
            run_frame(32'd11, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5, 1'b0);
        end
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
